// File: rtl/pair_serializer.sv
// pair_serializer
//   Sits downstream of the 2-input compare-and-swap sorter. Every pair the
//   sorter presents on y_valid is captured into a small FIFO. Pairs are then
//   streamed out one element per valid/ready transfer: element 0 first, then
//   element 1. The sorter has no back-pressure, so a pair that arrives while
//   the FIFO is full (and not popping that same cycle) is dropped. A drop sets
//   the sticky overflow flag.
//
// Parameters
//   DATA_WIDTH : element width, must match the sorter.
//   DEPTH      : FIFO capacity in pairs (power of two, >= 2).
//
// Ports
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   in_valid, in_0, in_1      : sorted pair from the sorter (y_valid, y_0, y_1)
//   out_data/out_valid/out_ready : element stream to the consumer
//   out_last                  : out_data is element 1 of its pair
//   count                     : pairs held, including a half-sent pair
//   full                      : count == DEPTH
//   overflow                  : sticky, set when a pair is dropped
//   drop_cnt                  : saturating 8-bit drop counter, present only
//                               when PAIR_SERIALIZER_DROP_CNT_EN is defined
module pair_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_0,
  input  logic [DATA_WIDTH-1:0]    in_1,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
`ifdef PAIR_SERIALIZER_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    sel;
  logic [2*DATA_WIDTH-1:0] head;
  logic                    xfer;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_last  = out_valid && sel;
  // Storage is not reset, so the data path is gated to 0 while empty.
  assign out_data  = !out_valid ? '0 :
                     (sel ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0]);

  assign xfer = out_valid && out_ready;
  // An entry leaves only once its second element has been taken.
  assign pop  = xfer && sel;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_1, in_0};
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sel      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (xfer) sel    <= !sel;
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PAIR_SERIALIZER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    drop_cnt <= 8'd0;
    else if (drop) drop_cnt <= sat_inc(drop_cnt);
  end
`endif

endmodule
